dwt_level_sequencer: RTL and testbench

Multi-level scheduler for the 2-D DWT 9/7 pipeline. It holds one tile configuration and, for each decomposition level, generates the read-address/framing stream that feeds the pipeline's slave port from the tile buffer. It counts the pipeline's output beats so that level l+1 reads do not start until level l writeback has fully completed, which keeps in-place writeback safe. It sits between the tile-buffer control and the DWT pipeline input.

---
 rtl/dwt_ctrl_pkg.sv | 45 ++++
 rtl/dwt_addr_gen.sv | 63 ++++++
 rtl/dwt_level_sequencer.sv | 154 +++++++++++++++
 tb/tb_dwt_level_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dwt_ctrl_pkg.sv
// Shared geometry constants, FSM encoding and configuration check for the
// multi-level DWT read sequencer.
package dwt_ctrl_pkg;

  localparam int MAX_SIDE   = 512;
  localparam int MAX_LEVELS = 5;
  localparam int PITCH      = MAX_SIDE / 2;
  localparam int ADDR_W     = $clog2(MAX_SIDE * MAX_SIDE / 2);
  localparam int DIM_W      = $clog2(MAX_SIDE) + 1;
  localparam int LVL_W      = $clog2(MAX_LEVELS + 1);
  localparam int LIDX_W     = $clog2(MAX_LEVELS);
  localparam int COL_W      = $clog2(PITCH);
  localparam int ROW_W      = $clog2(MAX_SIDE);
  localparam int CNT_W      = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Every level must split evenly and the deepest level must stay at least 4 samples wide.
  function automatic logic cfg_valid(input logic [DIM_W-1:0] width,
                                     input logic [DIM_W-1:0] height,
                                     input logic [LVL_W-1:0] levels);
    logic [DIM_W-1:0] mask;
    logic [LVL_W-1:0] top_shift;
    logic             ok;
    mask      = '0;
    top_shift = '0;
    ok = (levels != LVL_W'(0)) && (levels <= LVL_W'(MAX_LEVELS)) &&
         (width <= DIM_W'(MAX_SIDE)) && (height <= DIM_W'(MAX_SIDE));
    if (ok) begin
      mask      = (DIM_W'(1) << levels) - DIM_W'(1);
      top_shift = levels - LVL_W'(1);
      ok = ((width & mask) == DIM_W'(0)) && ((height & mask) == DIM_W'(0)) &&
           ((width >> top_shift) >= DIM_W'(4)) && ((height >> top_shift) >= DIM_W'(4));
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/dwt_addr_gen.sv
// Row-major beat walker over a Bl x Hl region of the tile buffer with a
// valid/ready command port; reloaded once per decomposition level.
module dwt_addr_gen
  import dwt_ctrl_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [COL_W-1:0]  i_bl_m1,
  input  logic [ROW_W-1:0]  i_hl_m1,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_sof,
  output logic              o_eol,
  output logic              o_last
);

  logic             r_valid;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic [COL_W-1:0] r_bl_m1;
  logic [ROW_W-1:0] r_hl_m1;
  logic             w_last;

  assign w_last = r_valid && (r_col == r_bl_m1) && (r_row == r_hl_m1);

  // Command position; advances only when the tile buffer accepts the beat.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_row   <= '0;
      r_col   <= '0;
      r_bl_m1 <= '0;
      r_hl_m1 <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_row   <= '0;
      r_col   <= '0;
      r_bl_m1 <= i_bl_m1;
      r_hl_m1 <= i_hl_m1;
    end else if (r_valid && i_ready) begin
      if (w_last) begin
        r_valid <= 1'b0;
        r_row   <= '0;
        r_col   <= '0;
      end else if (r_col == r_bl_m1) begin
        r_col <= '0;
        r_row <= r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // Pitch is a power of two, so row*Pitch+col is a plain concatenation.
  assign o_valid = r_valid;
  assign o_addr  = {r_row, r_col};
  assign o_sof   = r_valid && (r_row == ROW_W'(0)) && (r_col == COL_W'(0));
  assign o_eol   = r_valid && (r_col == r_bl_m1);
  assign o_last  = w_last;

endmodule

// File: rtl/dwt_level_sequencer.sv
// Multi-level DWT read scheduler: issues per-level read commands and holds the
// next level back until every output beat of the current level has drained.
module dwt_level_sequencer
  import dwt_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DIM_W-1:0]  width_i,
  input  logic [DIM_W-1:0]  height_i,
  input  logic [LVL_W-1:0]  levels_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              cfg_err_o,
  output logic [LIDX_W-1:0] level_o,
  input  logic              rd_ready_i,
  output logic              rd_valid_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              rd_sof_o,
  output logic              rd_eol_o,
  input  logic              out_valid_i,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] wr_index_o
);

  state_e            r_state;
  logic [DIM_W-1:0]  r_width;
  logic [DIM_W-1:0]  r_height;
  logic [LVL_W-1:0]  r_levels;
  logic [LIDX_W-1:0] r_level;
  logic [CNT_W-1:0]  r_out_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_cfg_err;

  logic              w_cfg_ok;
  logic              w_final;
  logic [CNT_W-1:0]  w_nl;
  logic              w_cnt_hit;
  logic              w_cnt_next_hit;
  logic              w_out_fire;
  logic              w_load;
  logic [LIDX_W-1:0] w_src_lvl;
  logic [DIM_W-1:0]  w_src_w;
  logic [DIM_W-1:0]  w_src_h;
  logic [COL_W-1:0]  w_ld_bl_m1;
  logic [ROW_W-1:0]  w_ld_hl_m1;
  logic              w_rd_valid;
  logic              w_rd_last;
  logic              w_rd_fire;

  assign w_cfg_ok       = cfg_valid(width_i, height_i, levels_i);
  assign w_final        = (r_level == LIDX_W'(r_levels - LVL_W'(1)));
  assign w_nl           = CNT_W'(r_width >> (r_level + LIDX_W'(1))) * CNT_W'(r_height >> r_level);
  assign w_out_fire     = out_valid_i && out_ready_i && r_busy;
  assign w_cnt_hit      = (r_out_cnt == w_nl);
  assign w_cnt_next_hit = w_out_fire && ((r_out_cnt + CNT_W'(1)) == w_nl);
  assign w_rd_fire      = w_rd_valid && rd_ready_i;

  // A load starts level 0 from the live inputs, or the next level from the latched job.
  assign w_load     = ((r_state == ST_IDLE) && start_i && w_cfg_ok) ||
                      ((r_state == ST_DRAIN) && !w_final && w_cnt_hit);
  assign w_src_lvl  = (r_state == ST_IDLE) ? LIDX_W'(0) : (r_level + LIDX_W'(1));
  assign w_src_w    = (r_state == ST_IDLE) ? width_i : r_width;
  assign w_src_h    = (r_state == ST_IDLE) ? height_i : r_height;
  assign w_ld_bl_m1 = COL_W'((w_src_w >> (w_src_lvl + LIDX_W'(1))) - DIM_W'(1));
  assign w_ld_hl_m1 = ROW_W'((w_src_h >> w_src_lvl) - DIM_W'(1));

  dwt_addr_gen u_addr_gen (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_load  (w_load),
    .i_bl_m1 (w_ld_bl_m1),
    .i_hl_m1 (w_ld_hl_m1),
    .i_ready (rd_ready_i),
    .o_valid (w_rd_valid),
    .o_addr  (rd_addr_o),
    .o_sof   (rd_sof_o),
    .o_eol   (rd_eol_o),
    .o_last  (w_rd_last)
  );

  // Output-beat counter; cleared whenever a level (re)starts.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out_cnt <= '0;
    end else if (w_load) begin
      r_out_cnt <= '0;
    end else if (w_out_fire) begin
      r_out_cnt <= r_out_cnt + CNT_W'(1);
    end
  end

  // Job FSM; the final level finishes on the accepting beat itself.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_width   <= '0;
      r_height  <= '0;
      r_levels  <= '0;
      r_level   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_i && w_cfg_ok) begin
            r_width  <= width_i;
            r_height <= height_i;
            r_levels <= levels_i;
            r_level  <= '0;
            r_busy   <= 1'b1;
            r_state  <= ST_READ;
          end else if (start_i) begin
            r_cfg_err <= 1'b1;
          end
        end
        ST_READ: begin
          if (w_rd_fire && w_rd_last) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_final && (w_cnt_hit || w_cnt_next_hit)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (!w_final && w_cnt_hit) begin
            r_level <= r_level + LIDX_W'(1);
            r_state <= ST_READ;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign cfg_err_o  = r_cfg_err;
  assign level_o    = r_level;
  assign rd_valid_o = w_rd_valid;
  assign wr_index_o = r_out_cnt[ADDR_W-1:0];

endmodule

// File: tb/tb_dwt_level_sequencer.sv
// Directed bench for dwt_level_sequencer: expected addresses/framing come from
// row*256+col arithmetic, timing from the documented cycle relationships.
module tb_dwt_level_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [9:0]  width_i;
  logic [9:0]  height_i;
  logic [2:0]  levels_i;
  logic        busy_o;
  logic        done_o;
  logic        cfg_err_o;
  logic [2:0]  level_o;
  logic        rd_ready_i;
  logic        rd_valid_o;
  logic [16:0] rd_addr_o;
  logic        rd_sof_o;
  logic        rd_eol_o;
  logic        out_valid_i;
  logic        out_ready_i;
  logic [16:0] wr_index_o;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;

  dwt_level_sequencer dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .width_i     (width_i),
    .height_i    (height_i),
    .levels_i    (levels_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .cfg_err_o   (cfg_err_o),
    .level_o     (level_o),
    .rd_ready_i  (rd_ready_i),
    .rd_valid_o  (rd_valid_o),
    .rd_addr_o   (rd_addr_o),
    .rd_sof_o    (rd_sof_o),
    .rd_eol_o    (rd_eol_o),
    .out_valid_i (out_valid_i),
    .out_ready_i (out_ready_i),
    .wr_index_o  (wr_index_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (done_o) n_done++;

  initial begin
    #500000;
    $display("FAIL watchdog expired got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_job(input int w, input int h, input int l);
    width_i  = 10'(w);
    height_i = 10'(h);
    levels_i = 3'(l);
    start_i  = 1'b1;
    step();
    start_i  = 1'b0;
  endtask

  // Every cycle with a valid command is compared against beat k; k only moves on acceptance.
  task automatic run_reads(input int n, input int bl, input bit rnd);
    int k;
    int cyc;
    k   = 0;
    cyc = 0;
    while (k < n && cyc < 4000) begin
      rd_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd_valid_o) begin
        chk("rd_addr", int'(rd_addr_o), (k / bl) * 256 + (k % bl));
        chk("rd_sof", int'(rd_sof_o), int'(k == 0));
        chk("rd_eol", int'(rd_eol_o), int'((k % bl) == bl - 1));
        if (rd_ready_i) k++;
      end
      step();
      cyc++;
    end
    chk("rd_count", k, n);
    rd_ready_i = 1'b0;
  endtask

  task automatic send_outs(input int n);
    out_valid_i = 1'b1;
    out_ready_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      chk("wr_index", int'(wr_index_o), i + 1);
    end
    out_valid_i = 1'b0;
  endtask

  task automatic try_bad(input string tag, input int w, input int h, input int l);
    start_job(w, h, l);
    chk(tag, int'(cfg_err_o), 1);
    chk("err_busy", int'(busy_o), 0);
    chk("err_rd_valid", int'(rd_valid_o), 0);
    step();
    chk("err_pulse_end", int'(cfg_err_o), 0);
  endtask

  task automatic check_all_zero();
    chk("z_busy", int'(busy_o), 0);
    chk("z_done", int'(done_o), 0);
    chk("z_cfg_err", int'(cfg_err_o), 0);
    chk("z_rd_valid", int'(rd_valid_o), 0);
    chk("z_rd_sof", int'(rd_sof_o), 0);
    chk("z_rd_eol", int'(rd_eol_o), 0);
    chk("z_rd_addr", int'(rd_addr_o), 0);
    chk("z_level", int'(level_o), 0);
    chk("z_wr_index", int'(wr_index_o), 0);
  endtask

  task automatic job_8x8(input bit rnd);
    int d0;
    d0 = n_done;
    start_job(8, 8, 1);
    chk("start_busy", int'(busy_o), 1);
    chk("start_lat", int'(rd_valid_o), 1);
    run_reads(32, 4, rnd);
    chk("rd_end", int'(rd_valid_o), 0);
    send_outs(32);
    chk("done_rise", int'(done_o), 1);
    chk("busy_fall", int'(busy_o), 0);
    step();
    chk("done_fall", int'(done_o), 0);
    chk("done_count", n_done - d0, 1);
  endtask

  initial begin
    int seen;
    int errs;
    int d0;
    rst_i       = 1'b1;
    start_i     = 1'b0;
    width_i     = '0;
    height_i    = '0;
    levels_i    = '0;
    rd_ready_i  = 1'b0;
    out_valid_i = 1'b0;
    out_ready_i = 1'b0;
    step();
    step();
    check_all_zero();
    rst_i = 1'b0;
    step();

    // 8x8, one level, continuous ready
    job_8x8(1'b0);

    // 16x16, two levels, with barrier and a start while busy
    d0 = n_done;
    start_job(16, 16, 2);
    chk("l0_level", int'(level_o), 0);
    run_reads(128, 8, 1'b0);
    seen = 0;
    errs = 0;
    width_i  = 10'd8;
    height_i = 10'd8;
    levels_i = 3'd1;
    start_i  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      start_i = 1'b0;
      if (rd_valid_o) seen++;
      if (cfg_err_o) errs++;
    end
    chk("barrier_no_reads", seen, 0);
    chk("busy_start_no_err", errs, 0);
    chk("barrier_level", int'(level_o), 0);
    send_outs(128);
    chk("drain_gap", int'(rd_valid_o), 0);
    step();
    chk("l1_rd_valid", int'(rd_valid_o), 1);
    chk("l1_level", int'(level_o), 1);
    chk("l1_wr_index", int'(wr_index_o), 0);
    run_reads(32, 4, 1'b0);
    send_outs(32);
    chk("l1_done", int'(done_o), 1);
    step();
    chk("two_level_done_count", n_done - d0, 1);

    // read backpressure
    job_8x8(1'b1);

    // configuration errors
    try_bad("err_div", 12, 16, 3);
    try_bad("err_lvl0", 8, 8, 0);
    try_bad("err_wide", 768, 8, 1);
    try_bad("err_lvl6", 512, 512, 6);
    try_bad("err_small", 8, 8, 3);

    // reset mid-READ of level 1
    d0 = n_done;
    start_job(16, 16, 2);
    run_reads(128, 8, 1'b0);
    send_outs(128);
    step();
    chk("rst_pre_level", int'(level_o), 1);
    run_reads(5, 4, 1'b0);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check_all_zero();
    out_valid_i = 1'b1;
    out_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) step();
    out_valid_i = 1'b0;
    chk("stray_wr_index", int'(wr_index_o), 0);
    chk("stray_busy", int'(busy_o), 0);
    chk("rst_no_done", n_done - d0, 0);
    job_8x8(1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
